// File: rtl/ysyx_23060124_wbu_if.sv
// rtl/ysyx_23060124_wbu_if.sv - execute-to-wbu, wbu-to-fetch and commit-side signal bundle
interface ysyx_23060124_wbu_if #(
  parameter int ISA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // execute -> wbu handshake and payload
  logic                      i_pre_valid;
  logic                      o_pre_ready;
  logic [ISA_WIDTH-1:0]      i_res;
  logic [ISA_WIDTH-1:0]      i_pc;
  logic [ISA_WIDTH-1:0]      i_imm;
  logic [ISA_WIDTH-1:0]      i_src1;
  logic [REG_ADDR_WIDTH-1:0] i_rd;
  logic                      i_rd_wen;
  logic                      i_brch;
  logic                      i_jal;
  logic                      i_jalr;
  logic                      i_ecall;
  logic                      i_mret;

  // current CSR values
  logic [ISA_WIDTH-1:0]      i_mtvec;
  logic [ISA_WIDTH-1:0]      i_mepc;

  // GPR / CSR commit strobes
  logic                      o_rd_wen;
  logic [REG_ADDR_WIDTH-1:0] o_rd;
  logic [ISA_WIDTH-1:0]      o_rd_wdata;
  logic                      o_ecall_wen;
  logic [ISA_WIDTH-1:0]      o_mepc_wdata;
  logic [ISA_WIDTH-1:0]      o_mcause_wdata;

  // wbu -> fetch handshake
  logic [ISA_WIDTH-1:0]      o_next_pc;
  logic                      o_post_valid;
  logic                      i_post_ready;

  // retired-instruction count
  logic [63:0]               o_retire_cnt;

  // the write-back unit itself
  modport slave (
    input  i_pre_valid, i_res, i_pc, i_imm, i_src1, i_rd, i_rd_wen,
           i_brch, i_jal, i_jalr, i_ecall, i_mret, i_mtvec, i_mepc, i_post_ready,
    output o_pre_ready, o_rd_wen, o_rd, o_rd_wdata, o_ecall_wen, o_mepc_wdata,
           o_mcause_wdata, o_next_pc, o_post_valid, o_retire_cnt
  );

  // the surrounding pipeline (execute, CSR file, fetch)
  modport master (
    output i_pre_valid, i_res, i_pc, i_imm, i_src1, i_rd, i_rd_wen,
           i_brch, i_jal, i_jalr, i_ecall, i_mret, i_mtvec, i_mepc, i_post_ready,
    input  o_pre_ready, o_rd_wen, o_rd, o_rd_wdata, o_ecall_wen, o_mepc_wdata,
           o_mcause_wdata, o_next_pc, o_post_valid, o_retire_cnt
  );
endinterface

// File: rtl/ysyx_23060124_wbu.sv
// rtl/ysyx_23060124_wbu.sv - write-back/commit stage: GPR write, ecall CSR update, next-PC handoff, retire count
module ysyx_23060124_wbu #(
  parameter int                   ISA_WIDTH      = 32,
  parameter int                   REG_ADDR_WIDTH = 5,
  parameter logic [ISA_WIDTH-1:0] RESET_PC       = 32'h8000_0000,
  parameter logic [ISA_WIDTH-1:0] ECALL_CAUSE    = 32'd11
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  ysyx_23060124_wbu_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMMIT  = 2'd1,
    S_HANDOFF = 2'd2
  } state_t;

  state_t                    r_state;

  // instruction captured at accept
  logic [ISA_WIDTH-1:0]      r_res;
  logic [ISA_WIDTH-1:0]      r_pc;
  logic [ISA_WIDTH-1:0]      r_imm;
  logic [ISA_WIDTH-1:0]      r_src1;
  logic [ISA_WIDTH-1:0]      r_mepc;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_brch;
  logic                      r_jal;
  logic                      r_jalr;
  logic                      r_mret;

  // registered outputs
  logic                      r_rd_wen_o;
  logic                      r_ecall_wen_o;
  logic                      r_ecall;
  logic                      r_post_valid;
  logic [ISA_WIDTH-1:0]      r_next_pc;
  logic [63:0]               r_retire_cnt;

  logic [ISA_WIDTH-1:0]      w_next_pc;
  logic                      w_accept;

  // the stage only takes work while idle; readiness never looks at i_pre_valid
  assign bus.o_pre_ready    = (r_state == S_IDLE);
  assign w_accept           = bus.i_pre_valid && (r_state == S_IDLE);

  assign bus.o_rd_wen       = r_rd_wen_o;
  assign bus.o_rd           = r_rd;
  assign bus.o_rd_wdata     = r_res;
  assign bus.o_ecall_wen    = r_ecall_wen_o;
  assign bus.o_mepc_wdata   = r_pc;
  assign bus.o_mcause_wdata = ECALL_CAUSE;
  assign bus.o_next_pc      = r_next_pc;
  assign bus.o_post_valid   = r_post_valid;
  assign bus.o_retire_cnt   = r_retire_cnt;

  // next-PC priority: trap entry, trap return, indirect jump, direct jump, taken branch, sequential
  always_comb begin
    w_next_pc = r_pc + ISA_WIDTH'(4);
    if (r_ecall) begin
      w_next_pc = bus.i_mtvec;
    end else if (r_mret) begin
      w_next_pc = r_mepc;
    end else if (r_jalr) begin
      w_next_pc = (r_src1 + r_imm) & ~ISA_WIDTH'(1);
    end else if (r_jal) begin
      w_next_pc = r_pc + r_imm;
    end else if (r_brch && r_res[0]) begin
      w_next_pc = r_pc + r_imm;
    end
  end

  // IDLE -> COMMIT -> HANDOFF sequencing with capture, one-cycle strobes and the PC handoff
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_res         <= '0;
      r_pc          <= '0;
      r_imm         <= '0;
      r_src1        <= '0;
      r_mepc        <= '0;
      r_rd          <= '0;
      r_brch        <= 1'b0;
      r_jal         <= 1'b0;
      r_jalr        <= 1'b0;
      r_ecall       <= 1'b0;
      r_mret        <= 1'b0;
      r_rd_wen_o    <= 1'b0;
      r_ecall_wen_o <= 1'b0;
      r_post_valid  <= 1'b0;
      r_next_pc     <= RESET_PC;
      r_retire_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_res         <= bus.i_res;
            r_pc          <= bus.i_pc;
            r_imm         <= bus.i_imm;
            r_src1        <= bus.i_src1;
            r_mepc        <= bus.i_mepc;
            r_rd          <= bus.i_rd;
            r_brch        <= bus.i_brch;
            r_jal         <= bus.i_jal;
            r_jalr        <= bus.i_jalr;
            r_ecall       <= bus.i_ecall;
            r_mret        <= bus.i_mret;
            // x0 is hardwired: a write request to it is dropped here
            r_rd_wen_o    <= bus.i_rd_wen && (bus.i_rd != '0);
            r_ecall_wen_o <= bus.i_ecall;
            r_state       <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_rd_wen_o    <= 1'b0;
          r_ecall_wen_o <= 1'b0;
          r_next_pc     <= w_next_pc;
          r_post_valid  <= 1'b1;
          r_retire_cnt  <= r_retire_cnt + 64'd1;
          r_state       <= S_HANDOFF;
        end
        S_HANDOFF: begin
          if (bus.i_post_ready) begin
            r_post_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_rd_wen_o    <= 1'b0;
          r_ecall_wen_o <= 1'b0;
          r_post_valid  <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// tb/tb_ysyx_23060124_wbu.sv - bench for ysyx_23060124_wbu: directed table, random vectors, reset corners
module tb_ysyx_23060124_wbu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] CAUSE    = 32'd11;

  logic clk;
  logic rst_n;

  ysyx_23060124_wbu_if #(.ISA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  ysyx_23060124_wbu #(
    .ISA_WIDTH(32), .REG_ADDR_WIDTH(5), .RESET_PC(RESET_PC), .ECALL_CAUSE(CAUSE)
  ) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res, pc, imm, src1, mtvec, mepc;
    logic [4:0]  rd;
    logic        rd_wen, brch, jal, jalr, ecall, mret;
    int          stall;
    logic        exp_rd_wen, exp_ecall_wen;
    logic [31:0] exp_next_pc;
  } vec_t;

  int          n_vec;
  int          n_cmp;
  int          n_err;
  logic [63:0] model_retire;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // architectural next-PC rule for one committed instruction
  function automatic logic [31:0] ref_next_pc(input vec_t v);
    if (v.ecall)                 return v.mtvec;
    if (v.mret)                  return v.mepc;
    if (v.jalr)                  return (v.src1 + v.imm) & 32'hFFFF_FFFE;
    if (v.jal)                   return v.pc + v.imm;
    if (v.brch && v.res[0])      return v.pc + v.imm;
    return v.pc + 32'd4;
  endfunction

  function automatic vec_t mk(input logic [31:0] res, pc, imm, src1, mtvec, mepc,
                              input logic [4:0] rd, input logic rd_wen,
                              input logic brch, jal, jalr, ecall, mret, input int stall,
                              input logic e_rd_wen, e_ecall_wen, input logic [31:0] e_npc);
    vec_t v;
    v.res = res; v.pc = pc; v.imm = imm; v.src1 = src1; v.mtvec = mtvec; v.mepc = mepc;
    v.rd = rd; v.rd_wen = rd_wen; v.brch = brch; v.jal = jal; v.jalr = jalr;
    v.ecall = ecall; v.mret = mret; v.stall = stall;
    v.exp_rd_wen = e_rd_wen; v.exp_ecall_wen = e_ecall_wen; v.exp_next_pc = e_npc;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.i_pre_valid = 1'b0; bus.i_res = '0; bus.i_pc = '0; bus.i_imm = '0; bus.i_src1 = '0;
    bus.i_rd = '0; bus.i_rd_wen = 1'b0; bus.i_brch = 1'b0; bus.i_jal = 1'b0; bus.i_jalr = 1'b0;
    bus.i_ecall = 1'b0; bus.i_mret = 1'b0; bus.i_post_ready = 1'b0;
  endtask

  // one full accept / commit / handoff transaction, called just after a rising edge in IDLE
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] npc;
    n_vec++;
    chk({tag, ".pre_ready_idle"}, 64'(bus.o_pre_ready), 64'd1);
    bus.i_res = v.res; bus.i_pc = v.pc; bus.i_imm = v.imm; bus.i_src1 = v.src1;
    bus.i_rd = v.rd; bus.i_rd_wen = v.rd_wen; bus.i_brch = v.brch; bus.i_jal = v.jal;
    bus.i_jalr = v.jalr; bus.i_ecall = v.ecall; bus.i_mret = v.mret;
    bus.i_mtvec = v.mtvec; bus.i_mepc = v.mepc; bus.i_post_ready = 1'b0;
    bus.i_pre_valid = 1'b1;
    @(posedge clk); #1;
    // COMMIT: the execute stage moves on, CSR file still holds mtvec
    bus.i_pre_valid = 1'b0;
    bus.i_mepc = ~v.mepc;
    chk({tag, ".rd_wen"}, 64'(bus.o_rd_wen), 64'(v.exp_rd_wen));
    if (v.exp_rd_wen) begin
      chk({tag, ".rd"}, 64'(bus.o_rd), 64'(v.rd));
      chk({tag, ".rd_wdata"}, 64'(bus.o_rd_wdata), 64'(v.res));
    end
    chk({tag, ".ecall_wen"}, 64'(bus.o_ecall_wen), 64'(v.exp_ecall_wen));
    if (v.exp_ecall_wen) begin
      chk({tag, ".mepc_wdata"}, 64'(bus.o_mepc_wdata), 64'(v.pc));
      chk({tag, ".mcause"}, 64'(bus.o_mcause_wdata), 64'(CAUSE));
    end
    chk({tag, ".pre_ready_commit"}, 64'(bus.o_pre_ready), 64'd0);
    chk({tag, ".post_valid_commit"}, 64'(bus.o_post_valid), 64'd0);
    @(posedge clk); #1;
    model_retire++;
    npc = v.exp_next_pc;
    chk({tag, ".post_valid"}, 64'(bus.o_post_valid), 64'd1);
    chk({tag, ".next_pc"}, 64'(bus.o_next_pc), 64'(npc));
    chk({tag, ".strobes_off"}, 64'({bus.o_rd_wen, bus.o_ecall_wen}), 64'd0);
    chk({tag, ".retire"}, bus.o_retire_cnt, model_retire);
    // fetch stalls; a fresh execute result waiting must not be taken
    for (int s = 0; s < v.stall; s++) begin
      bus.i_pre_valid = 1'b1;
      bus.i_pc = v.pc ^ 32'h0000_1000;
      @(posedge clk); #1;
      chk({tag, ".stall_valid"}, 64'(bus.o_post_valid), 64'd1);
      chk({tag, ".stall_pc"}, 64'(bus.o_next_pc), 64'(npc));
      chk({tag, ".stall_pre_ready"}, 64'(bus.o_pre_ready), 64'd0);
      chk({tag, ".stall_retire"}, bus.o_retire_cnt, model_retire);
    end
    bus.i_pre_valid = 1'b0;
    bus.i_post_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_post_ready = 1'b0;
    chk({tag, ".post_valid_drop"}, 64'(bus.o_post_valid), 64'd0);
    chk({tag, ".pre_ready_back"}, 64'(bus.o_pre_ready), 64'd1);
    chk({tag, ".next_pc_hold"}, 64'(bus.o_next_pc), 64'(npc));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".next_pc"}, 64'(bus.o_next_pc), 64'(RESET_PC));
    chk({tag, ".pre_ready"}, 64'(bus.o_pre_ready), 64'd1);
    chk({tag, ".post_valid"}, 64'(bus.o_post_valid), 64'd0);
    chk({tag, ".retire"}, bus.o_retire_cnt, 64'd0);
    chk({tag, ".strobes"}, 64'({bus.o_rd_wen, bus.o_ecall_wen}), 64'd0);
  endtask

  initial begin
    vec_t v;
    int   cls;
    n_vec = 0; n_cmp = 0; n_err = 0; model_retire = '0;
    idle_inputs();
    bus.i_mtvec = '0; bus.i_mepc = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("reset_idle");

    //          res           pc            imm           src1          mtvec         mepc          rd  wen br jl jr ec mr st  erd eec enpc
    tbl.push_back(mk(32'h0000_1234, 32'h8000_0010, 32'h0,         32'h0,      32'h0,   32'h0,   5'd5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0014));
    tbl.push_back(mk(32'h0000_0001, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0,      32'h0,   32'h0,   5'd0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0000_00F0));
    tbl.push_back(mk(32'h0000_0000, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0,      32'h0,   32'h0,   5'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0104));
    tbl.push_back(mk(32'h0000_010C, 32'h0000_0108, 32'h0000_0004, 32'h2003,   32'h0,   32'h0,   5'd1, 1, 0, 0, 1, 0, 0, 2, 1, 0, 32'h0000_2006));
    tbl.push_back(mk(32'h0000_0000, 32'h0000_0200, 32'h0,         32'h0,      32'h400, 32'h0,   5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0400));
    tbl.push_back(mk(32'h0000_0000, 32'h0000_0410, 32'h0,         32'h0,      32'h400, 32'h204, 5'd0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 32'h0000_0204));
    tbl.push_back(mk(32'hDEAD_BEEF, 32'h0000_0300, 32'h0,         32'h0,      32'h0,   32'h0,   5'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0304));
    tbl.push_back(mk(32'h0000_1004, 32'h0000_1000, 32'h0000_0020, 32'h0,      32'h0,   32'h0,   5'd1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0000_1020));
    tbl.push_back(mk(32'h0000_0042, 32'hFFFF_FFFC, 32'h0,         32'h0,      32'h0,   32'h0,   5'd31,1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0000));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // randomized instructions, expectations from the architectural model
    for (int k = 0; k < 200; k++) begin
      v.res = $urandom; v.pc = $urandom & 32'hFFFF_FFFC; v.imm = $urandom;
      v.src1 = $urandom; v.mtvec = $urandom; v.mepc = $urandom;
      v.rd = 5'($urandom_range(0, 31)); v.rd_wen = 1'($urandom_range(0, 1));
      cls = $urandom_range(0, 5);
      v.brch = (cls == 1); v.jal = (cls == 2); v.jalr = (cls == 3);
      v.ecall = (cls == 4); v.mret = (cls == 5);
      v.stall = $urandom_range(0, 3);
      v.exp_rd_wen = v.rd_wen && (v.rd != 5'd0);
      v.exp_ecall_wen = v.ecall;
      v.exp_next_pc = ref_next_pc(v);
      run_vec(v, $sformatf("rnd%0d", k));
    end

    // asynchronous reset while the next PC is waiting for fetch
    n_vec++;
    bus.i_pc = 32'h0000_5000; bus.i_res = 32'h77; bus.i_rd = 5'd3; bus.i_rd_wen = 1'b1;
    bus.i_brch = 1'b0; bus.i_jal = 1'b0; bus.i_jalr = 1'b0; bus.i_ecall = 1'b0; bus.i_mret = 1'b0;
    bus.i_pre_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_pre_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.post_valid_before", 64'(bus.o_post_valid), 64'd1);
    chk("rst_mid.next_pc_before", 64'(bus.o_next_pc), 64'h5004);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_retire = '0;
    @(posedge clk); #1;
    check_reset_state("rst_mid_after");

    // the stage is fully usable after the mid-flight reset
    run_vec(tbl[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running want finished)");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_23060124_wbu.md
Name: ysyx_23060124_wbu

Overview:
Write-back/commit stage directly downstream of the execute stage.
- Captures one executed instruction per valid/ready handshake and commits it: GPR write, ecall CSR side effects, next-PC selection.
- Hands the next PC to the fetch stage over a valid/ready handshake.
- Counts retired instructions.

Parameters:
ISA_WIDTH, 32, datapath/PC width
REG_ADDR_WIDTH, 5, GPR index width
RESET_PC, 32'h8000_0000, o_next_pc value after reset
ECALL_CAUSE, 32'd11, mcause value written on ecall (M-mode ecall)

Ports:
clk  in  1  single clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_pre_valid  in  1  execute stage has a result
o_pre_ready  out  1  wbu can accept a result
i_res  in  ISA_WIDTH  execute result; {31'b0,taken} for branches; pc+4 for jal/jalr
i_pc  in  ISA_WIDTH  PC of the instruction
i_imm  in  ISA_WIDTH  immediate
i_src1  in  ISA_WIDTH  rs1 value (jalr base)
i_rd  in  REG_ADDR_WIDTH  destination register
i_rd_wen  in  1  instruction writes rd
i_brch, i_jal, i_jalr, i_ecall, i_mret  in  1 each  instruction class, at most one set
i_mtvec, i_mepc  in  ISA_WIDTH  current CSR values
o_rd_wen  out  1  GPR write strobe
o_rd  out  REG_ADDR_WIDTH  GPR write index
o_rd_wdata  out  ISA_WIDTH  GPR write data
o_ecall_wen  out  1  strobe: write mepc<=o_mepc_wdata, mcause<=ECALL_CAUSE
o_mepc_wdata  out  ISA_WIDTH  faulting PC
o_next_pc  out  ISA_WIDTH  PC for fetch
o_post_valid  out  1  o_next_pc valid for fetch
i_post_ready  in  1  fetch accepts o_next_pc
o_retire_cnt  out  64  retired-instruction count

Behaviour:
- States: IDLE, COMMIT, HANDOFF.
- Reset (async, any state, including mid-operation): state=IDLE, o_rd_wen=0, o_ecall_wen=0, o_post_valid=0, o_next_pc=RESET_PC, o_retire_cnt=0, all capture registers 0.
- o_pre_ready = (state==IDLE). Combinational from state only; never depends on i_pre_valid.
- IDLE: when i_pre_valid && o_pre_ready at an edge:
  - register all inputs;
  - go to COMMIT.
- COMMIT (exactly 1 cycle):
  - o_rd_wen=1 iff captured rd_wen && rd!=0; o_rd=rd; o_rd_wdata=res.
  - o_ecall_wen=1 iff captured ecall; o_mepc_wdata=pc.
  - o_next_pc is registered at the end of COMMIT, selected by priority:
    1. ecall: i_mtvec
    2. mret: captured mepc
    3. jalr: (src1+imm) & ~1
    4. jal: pc+imm
    5. brch && res[0]: pc+imm
    6. otherwise: pc+4
  - All additions are mod 2^ISA_WIDTH.
  - o_retire_cnt increments by 1 (64-bit wrap).
  - Next state: HANDOFF.
- HANDOFF:
  - o_post_valid=1. o_next_pc stable until accepted.
  - i_post_ready=1: go to IDLE; o_post_valid falls the next cycle.
  - i_post_ready=0: stay in HANDOFF, indefinitely if needed.
- Outside COMMIT: o_rd_wen=0 and o_ecall_wen=0 (one-cycle strobes).
- Throughput: one instruction per 3 cycles minimum; the handshake adds +1 cycle per stalled fetch cycle.
- Latency: 1 cycle from accept to the write strobe; 2 cycles from accept to o_post_valid.
- i_pre_valid while not IDLE: ignored; the execute stage holds its result.
- rd==0 with rd_wen=1: no GPR write, PC flow unchanged.
- mret uses i_mepc captured at accept; ecall uses i_mtvec sampled in COMMIT (CSR file is static between these points).

Test Plan:
- Reset: after reset, o_next_pc=32'h8000_0000, o_pre_ready=1, o_post_valid=0, o_retire_cnt=0.
- ALU op: accept pc=0x8000_0010, rd=5, res=0x1234, i_post_ready=1. Next cycle: o_rd_wen=1, o_rd=5, o_rd_wdata=0x1234. Following cycle: o_post_valid=1, o_next_pc=0x8000_0014. o_retire_cnt=1.
- Branch: brch=1, pc=0x100, imm=0xFFFF_FFF0, res=1 → o_next_pc=0xF0, o_rd_wen=0. With res=0 → o_next_pc=0x104.
- jalr: src1=0x2003, imm=4, rd=1, res=0x10C → o_next_pc=0x2006, x1<=0x10C.
- ecall/mret: ecall at pc=0x200, mtvec=0x400 → o_ecall_wen=1, o_mepc_wdata=0x200, o_next_pc=0x400. Then mret with mepc=0x204 → o_next_pc=0x204.
- Backpressure/reset: hold i_post_ready=0 for 5 cycles → o_post_valid and o_next_pc stable, o_pre_ready=0, a new i_pre_valid is not accepted. Assert i_rst_n=0 mid-HANDOFF → immediate IDLE, o_post_valid=0, o_next_pc=RESET_PC, counter cleared.
